// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
//   Main control FSM of a multicycle MIPS datapath. Walks each instruction
//   through fetch / decode / execute / memory / writeback, drives every
//   datapath mux select and write enable, hands AluOp to the downstream ALU
//   control decoder, stalls on the memory handshake and counts retired
//   instructions.
//
// Ports
//   clk          in   1      rising-edge clock
//   reset        in   1      asynchronous, active-high reset
//   Op           in   6      opcode from the instruction register (IR[31:26])
//   mem_ready    in   1      memory access completes this cycle
//   PCWrite      out  1      unconditional PC load
//   PCWriteCond  out  1      PC load qualified by ALU Zero (beq)
//   IorD         out  1      memory address: 0=PC, 1=ALUOut
//   MemRead      out  1      memory read request
//   MemWrite     out  1      memory write request
//   IRWrite      out  1      load the instruction register
//   MemtoReg     out  1      register write data: 0=ALUOut, 1=MDR
//   RegDst       out  1      destination register: 0=rt, 1=rd
//   RegWrite     out  1      register file write enable
//   AluSrcA      out  1      ALU A: 0=PC, 1=A register
//   AluSrcB      out  2      ALU B: 00=B, 01=4, 10=signext imm, 11=signext imm<<2
//   AluOp        out  2      00=add, 01=sub, 10=decode function field
//   PCSource     out  2      00=ALU result, 01=ALUOut, 10=jump target
//   illegal_op   out  1      one-cycle pulse: unsupported opcode seen in DECODE
//   state_o      out  4      current state encoding (debug)
//   instr_count  out  CNT_W  instructions retired since reset (wraps)
//
// Memory handshake: MemRead / MemWrite act as a request "valid" that is held
// high, with address and data selects stable, for every cycle the FSM sits in
// an access state. mem_ready is the "ready": the access completes on the
// first clock edge where both are high, and only then does the FSM advance.
// mem_ready is ignored in every state that issues no request.
// ----------------------------------------------------------------------------
module multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter int         CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Op,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             AluSrcA,
  output logic [1:0]       AluSrcB,
  output logic [1:0]       AluOp,
  output logic [1:0]       PCSource,
  output logic             illegal_op,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RTWB   = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10
  } state_t;

  // Mux select encodings, named for readability in the decode below.
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFS = 2'b11;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  state_t state;
  state_t state_next;
  logic   retire;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode. Outputs depend on state only (plus
  // mem_ready for the fetch-time IR/PC loads), so an asynchronous reset
  // forcing IDLE drops every request in the same cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next  = state;
    retire      = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    AluSrcA     = 1'b0;
    AluSrcB     = SRCB_REG;
    AluOp       = ALU_ADD;
    PCSource    = PC_ALU;
    illegal_op  = 1'b0;

    case (state)
      S_IDLE: begin
        state_next = S_FETCH;
      end

      S_FETCH: begin
        // PC+4 is computed every cycle, but IR and PC only load on the cycle
        // the read completes so a stalled fetch leaves both untouched.
        MemRead  = 1'b1;
        IorD     = 1'b0;
        AluSrcA  = 1'b0;
        AluSrcB  = SRCB_FOUR;
        AluOp    = ALU_ADD;
        PCSource = PC_ALU;
        IRWrite  = mem_ready;
        PCWrite  = mem_ready;
        if (mem_ready) begin
          state_next = S_DECODE;
        end
      end

      S_DECODE: begin
        // Speculatively form the branch target into ALUOut while decoding.
        AluSrcA = 1'b0;
        AluSrcB = SRCB_BOFS;
        AluOp   = ALU_ADD;
        if (Op == OP_LW || Op == OP_SW) begin
          state_next = S_MEMADR;
        end else if (Op == OP_RTYPE) begin
          state_next = S_EXEC;
        end else if (Op == OP_BEQ) begin
          state_next = S_BRANCH;
        end else if (Op == OP_J) begin
          state_next = S_JUMP;
        end else begin
          // Unsupported opcode: flag it and refetch without retiring.
          illegal_op = 1'b1;
          state_next = S_FETCH;
        end
      end

      S_MEMADR: begin
        AluSrcA = 1'b1;
        AluSrcB = SRCB_IMM;
        AluOp   = ALU_ADD;
        if (Op == OP_LW) begin
          state_next = S_MEMRD;
        end else begin
          state_next = S_MEMWR;
        end
      end

      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) begin
          state_next = S_MEMWB;
        end
      end

      S_MEMWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b0;
        MemtoReg   = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end

      S_MEMWR: begin
        // A store retires on the cycle its write is accepted.
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end
      end

      S_EXEC: begin
        AluSrcA    = 1'b1;
        AluSrcB    = SRCB_REG;
        AluOp      = ALU_FUNCT;
        state_next = S_RTWB;
      end

      S_RTWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        MemtoReg   = 1'b0;
        retire     = 1'b1;
        state_next = S_FETCH;
      end

      S_BRANCH: begin
        AluSrcA     = 1'b1;
        AluSrcB     = SRCB_REG;
        AluOp       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PC_ALUOUT;
        retire      = 1'b1;
        state_next  = S_FETCH;
      end

      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = PC_JUMP;
        retire     = 1'b1;
        state_next = S_FETCH;
      end

      default: begin
        // Unused encodings recover through IDLE.
        state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Retired-instruction counter; wraps naturally at 2^CNT_W.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_count <= '0;
    end else if (retire) begin
      instr_count <= instr_count + CNT_W'(1);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_multicycle_control.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control
//   Scripted-by-instruction bench for multicycle_control. The driver issues
//   whole instructions (opcode plus per-phase memory stall counts) and, for
//   every cycle it drives, pushes the expected {instr_count, state, control
//   word} into exp_q. The expected control word comes from a per-state table
//   of datapath settings; the state sequence comes from each opcode's phase
//   list. A monitor on the falling edge pops and compares one entry per cycle.
// ----------------------------------------------------------------------------
module tb_multicycle_control;

  localparam int         CNT_W  = 4;
  localparam int         VW     = CNT_W + 4 + 17;
  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEMADR = 3,
                 ST_MEMRD = 4, ST_MEMWB = 5, ST_MEMWR = 6, ST_EXEC = 7,
                 ST_RTWB = 8, ST_BRANCH = 9, ST_JUMP = 10;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [5:0]       Op = 6'd0;
  logic             mem_ready = 1'b0;
  logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic             MemtoReg, RegDst, RegWrite, AluSrcA;
  logic [1:0]       AluSrcB, AluOp, PCSource;
  logic             illegal_op;
  logic [3:0]       state_o;
  logic [CNT_W-1:0] instr_count;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Op(Op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluOp(AluOp), .PCSource(PCSource),
    .illegal_op(illegal_op), .state_o(state_o), .instr_count(instr_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [VW-1:0]    exp_q[$];
  logic [CNT_W-1:0] model_count = '0;
  logic             mon_en = 1'b0;
  int               total = 0;
  int               bad = 0;
  int               cycle = 0;

  // Datapath settings each state must present, bit order:
  // PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite
  // AluSrcA AluSrcB[2] AluOp[2] PCSource[2] illegal_op
  function automatic logic [16:0] exp_ctrl(input int st, input logic rdy,
                                           input logic ill);
    logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa;
    logic [1:0] asb, aop, pcs;
    {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      ST_FETCH:  begin mr = 1'b1; asb = 2'b01; irw = rdy; pcw = rdy; end
      ST_DECODE: asb = 2'b11;
      ST_MEMADR: begin asa = 1'b1; asb = 2'b10; end
      ST_MEMRD:  begin mr = 1'b1; iord = 1'b1; end
      ST_MEMWB:  begin rw = 1'b1; m2r = 1'b1; end
      ST_MEMWR:  begin mw = 1'b1; iord = 1'b1; end
      ST_EXEC:   begin asa = 1'b1; aop = 2'b10; end
      ST_RTWB:   begin rw = 1'b1; rd = 1'b1; end
      ST_BRANCH: begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
      ST_JUMP:   begin pcw = 1'b1; pcs = 2'b10; end
      default:   ;
    endcase
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs,
            (st == ST_DECODE) && ill};
  endfunction

  // ---------------- driver tasks ----------------
  // One cycle: drive mem_ready, record what the DUT must show, advance.
  task automatic step(input int st, input logic rdy, input logic ill);
    mem_ready = rdy;
    exp_q.push_back({model_count, 4'(st), exp_ctrl(st, rdy, ill)});
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Asserted right after an edge, so reset takes hold mid-cycle.
  task automatic do_reset(input int n);
    reset = 1'b1;
    model_count = '0;
    for (int i = 0; i < n; i++) step(ST_IDLE, rnd_bit(), 1'b0);
    reset = 1'b0;
    step(ST_IDLE, rnd_bit(), 1'b0);
  endtask

  // Runs one instruction from FETCH back to FETCH. fw / mw are the numbers
  // of stalled cycles (mem_ready low) in the fetch and data-memory phases.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    logic legal;
    legal = (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
            (op == OP_BEQ) || (op == OP_J);
    Op = op;
    for (int i = 0; i < fw; i++) step(ST_FETCH, 1'b0, 1'b0);
    step(ST_FETCH, 1'b1, 1'b0);
    step(ST_DECODE, rnd_bit(), !legal);
    if (legal) begin
      case (op)
        OP_LW: begin
          step(ST_MEMADR, rnd_bit(), 1'b0);
          for (int i = 0; i < mw; i++) step(ST_MEMRD, 1'b0, 1'b0);
          step(ST_MEMRD, 1'b1, 1'b0);
          step(ST_MEMWB, rnd_bit(), 1'b0);
        end
        OP_SW: begin
          step(ST_MEMADR, rnd_bit(), 1'b0);
          for (int i = 0; i < mw; i++) step(ST_MEMWR, 1'b0, 1'b0);
          step(ST_MEMWR, 1'b1, 1'b0);
        end
        OP_R: begin
          step(ST_EXEC, rnd_bit(), 1'b0);
          step(ST_RTWB, rnd_bit(), 1'b0);
        end
        OP_BEQ: step(ST_BRANCH, rnd_bit(), 1'b0);
        default: step(ST_JUMP, rnd_bit(), 1'b0);
      endcase
      model_count = model_count + 1'b1;
    end
  endtask

  function automatic logic [5:0] rand_op();
    int k;
    logic [5:0] op;
    k = $urandom_range(0, 5);
    case (k)
      0: op = OP_LW;
      1: op = OP_SW;
      2: op = OP_R;
      3: op = OP_BEQ;
      4: op = OP_J;
      default: begin
        op = 6'($urandom_range(0, 63));
        while (op == OP_R || op == OP_LW || op == OP_SW ||
               op == OP_BEQ || op == OP_J) op = 6'($urandom_range(0, 63));
      end
    endcase
    return op;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [VW-1:0] got;
    logic [VW-1:0] want;
    if (mon_en) begin
      cycle++;
      got = {instr_count, state_o, PCWrite, PCWriteCond, IorD, MemRead,
             MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, AluSrcA,
             AluSrcB, AluOp, PCSource, illegal_op};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_underflow cycle %0d: got %h, no expectation queued",
                 cycle, got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          bad++;
          $display("FAIL ctrl_vec cycle %0d: got cnt=%0d state=%0d ctrl=%h, want cnt=%0d state=%0d ctrl=%h",
                   cycle, got[VW-1 -: CNT_W], got[20:17], got[16:0],
                   want[VW-1 -: CNT_W], want[20:17], want[16:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    do_reset(3);                         // reset held 3 cycles, then IDLE->FETCH
    run_instr(OP_LW, 0, 0);              // lw, no stalls: 1,2,3,4,5,1
    run_instr(OP_SW, 3, 3);              // sw with 3 stall cycles in both phases
    run_instr(OP_R, 0, 0);
    run_instr(OP_BEQ, 1, 0);
    run_instr(OP_J, 0, 0);
    run_instr(6'b111111, 0, 0);          // illegal: pulse, no retire

    // Load stalled in MEMRD, then reset arrives before mem_ready.
    Op = OP_LW;
    step(ST_FETCH, 1'b1, 1'b0);
    step(ST_DECODE, 1'b0, 1'b0);
    step(ST_MEMADR, 1'b0, 1'b0);
    step(ST_MEMRD, 1'b0, 1'b0);
    step(ST_MEMRD, 1'b0, 1'b0);
    do_reset(2);

    // Seventeen jumps carry the 4-bit counter through its wrap.
    for (int i = 0; i < 17; i++) run_instr(OP_J, 0, 0);

    for (int i = 0; i < 150; i++)
      run_instr(rand_op(), $urandom_range(0, 3), $urandom_range(0, 3));

    mon_en = 1'b0;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the stimulus never completes.
  initial begin
    #200000;
    $display("FAIL timeout: stimulus did not complete, total=%0d", total);
    $fatal(1, "timeout");
  end

endmodule
